bar_step_counter: RTL

- Stopwatch-style step counter that produces the 4-bit BINARY code consumed by the 10-output one-hot bar decoder.
- Counts 1..MAX_VAL, one step every DIV clocks while running.
- Start/stop and clear come from the front-panel buttons; the wrap is reported to the next digit stage.
- BINARY is always a legal decoder code (1..MAX_VAL), never 0.

---
 rtl/bar_step_counter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/bar_step_counter.sv
// -----------------------------------------------------------------------------
// bar_step_counter
//
// Stopwatch-style step counter. It drives the 4-bit binary code that the
// 10-output one-hot bar decoder consumes. While running, the count advances
// 1..MAX_VAL by one step every DIV clocks and then wraps back to 1. The count
// never shows 0, so the decoder always receives a legal code.
//
// Parameters
//   DIV      clock cycles per count step (2..65535)
//   MAX_VAL  top count value before the wrap to 1 (2..15)
//
// Ports
//   CLK       system clock; all state changes on the rising edge
//   RESET_N   asynchronous, active-low reset
//   STRTSTOP  start/stop button level (synchronised); acts on its rising edge
//   CLR       clear request (level); honoured only while stopped
//   LAP       lap button level (synchronised); acts on its rising edge
//   BINARY    registered count code to the decoder, 1..MAX_VAL
//   CARRY     one-cycle pulse on the MAX_VAL->1 wrap, aligned with BINARY=1
//   RUNNING   high while the FSM is in RUN
//
// Build option
//   BAR_STEP_LAP_HOLD_EN  When defined, a LAP edge in RUN freezes BINARY and
//                         a second LAP edge releases it. Count, prescaler and
//                         CARRY keep running underneath. When not defined,
//                         LAP is ignored and BINARY always equals the count.
// -----------------------------------------------------------------------------
module bar_step_counter #(
   parameter int DIV     = 10,
   parameter int MAX_VAL = 10
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       STRTSTOP,
   input  logic       CLR,
   input  logic       LAP,
   output logic [3:0] BINARY,
   output logic       CARRY,
   output logic       RUNNING
);

   localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [3:0]    MAX_CODE   = 4'(MAX_VAL);

   typedef enum logic [1:0] {
      ST_CLEARED = 2'd0,
      ST_RUN     = 2'd1,
      ST_STOPPED = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic          strt_q;
   logic          armed_q;
   logic          strt_edge;
   logic          clr_stop;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    count_q, count_d;
   logic          carry_q, carry_d;
   logic          running_q;
   logic          presc_en;
   logic          step;

   // A button held through reset must not count as a press. The edge detector
   // is armed only once STRTSTOP has been seen low after reset.
   assign strt_edge = STRTSTOP & ~strt_q & armed_q;
   assign clr_stop  = (state_q == ST_STOPPED) && CLR;

   // NOTE: every signal written in an always_comb gets a default at the top of
   // the block. A path that leaves a signal unassigned would infer a latch.
   always_comb begin : fsm_next
      state_d = state_q;
      case (state_q)
         ST_CLEARED: if (strt_edge) state_d = ST_RUN;
         ST_RUN:     if (strt_edge) state_d = ST_STOPPED;
         ST_STOPPED: begin
            // CLR takes priority over a start edge in the same cycle.
            if (CLR)            state_d = ST_CLEARED;
            else if (strt_edge) state_d = ST_RUN;
         end
         default:    state_d = ST_CLEARED;
      endcase
   end

   // The prescaler advances on every edge that enters or leaves RUN, as well
   // as inside RUN. As a result, the first step lands DIV cycles after the
   // start-edge cycle, and a stop edge that coincides with a step still
   // completes that step.
   always_comb begin : datapath
      presc_en = (state_q == ST_RUN) || (state_d == ST_RUN);
      step     = presc_en && (presc_q == PRESC_LAST);
      presc_d  = presc_q;
      count_d  = count_q;
      carry_d  = 1'b0;

      if (presc_en) begin
         presc_d = step ? '0 : presc_q + PW'(1);
      end

      if (step) begin
         // Using >= keeps the code inside 1..MAX_VAL even from a corrupted count.
         if (count_q >= MAX_CODE) begin
            count_d = 4'd1;
            carry_d = 1'b1;
         end else begin
            count_d = count_q + 4'd1;
         end
      end

      if (clr_stop) begin
         count_d = 4'd1;
         presc_d = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only. All registers
   // then update together from values sampled before the edge.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= ST_CLEARED;
         strt_q    <= 1'b0;
         armed_q   <= 1'b0;
         presc_q   <= '0;
         count_q   <= 4'd1;
         carry_q   <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         strt_q    <= STRTSTOP;
         armed_q   <= armed_q | ~STRTSTOP;
         presc_q   <= presc_d;
         count_q   <= count_d;
         carry_q   <= carry_d;
         running_q <= (state_d == ST_RUN);
      end
   end

   assign CARRY   = carry_q;
   assign RUNNING = running_q;

`ifdef BAR_STEP_LAP_HOLD_EN
   logic       lap_q;
   logic       hold_q, hold_d;
   logic [3:0] disp_q, disp_d;

   always_comb begin : lap_hold
      hold_d = hold_q;
      if (clr_stop) begin
         hold_d = 1'b0;
      end else if ((state_q == ST_RUN) && LAP && !lap_q) begin
         hold_d = ~hold_q;
      end
      // While held, the display keeps the code it showed when the hold was
      // set. Releasing the hold shows the live count on the next cycle.
      disp_d = hold_d ? disp_q : count_d;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         lap_q  <= 1'b0;
         hold_q <= 1'b0;
         disp_q <= 4'd1;
      end else begin
         lap_q  <= LAP;
         hold_q <= hold_d;
         disp_q <= disp_d;
      end
   end

   assign BINARY = disp_q;
`else
   // LAP stays on the port list so the pinout matches the lap-hold build.
   logic lap_unused;
   assign lap_unused = LAP;
   assign BINARY     = count_q;
`endif

endmodule
